// File: rtl/alu_unit.sv
// 32-bit execute-stage ALU: one registered result per accepted operation,
// with zero flag and valid strobe one clock after in_valid.
module alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [3:0]       ALU_Sel,
  input  logic [WIDTH-1:0] operand_0,
  input  logic [WIDTH-1:0] operand_1,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             out_valid
);

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_OR  = 4'b0011,
    OP_XOR = 4'b0100,
    OP_SHL = 4'b0110,
    OP_SHR = 4'b0111,
    OP_SRA = 4'b1000,
    OP_SLT = 4'b1001
  } alu_op_e;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
  } alu_rsp_t;

  logic [4:0] shamt;
  logic       slt;
  alu_rsp_t   rsp_nxt;
  alu_rsp_t   rsp_q;
  logic       vld_q;

  // Only B[4:0] steers shifts; upper operand bits are deliberately ignored.
  assign shamt = operand_1[4:0];
  assign slt   = $signed(operand_0) < $signed(operand_1);

  always_comb begin
    rsp_nxt.res = '0;
    case (ALU_Sel)
      OP_ADD:  rsp_nxt.res = operand_0 + operand_1;
      OP_SUB:  rsp_nxt.res = operand_0 - operand_1;
      OP_AND:  rsp_nxt.res = operand_0 & operand_1;
      OP_OR:   rsp_nxt.res = operand_0 | operand_1;
      OP_XOR:  rsp_nxt.res = operand_0 ^ operand_1;
      OP_SHL:  rsp_nxt.res = operand_0 << shamt;
      OP_SHR:  rsp_nxt.res = operand_0 >> shamt;
      OP_SRA:  rsp_nxt.res = WIDTH'($signed(operand_0) >>> shamt);
      OP_SLT:  rsp_nxt.res = {{(WIDTH-1){1'b0}}, slt};
      default: rsp_nxt.res = '0;
    endcase
    rsp_nxt.zero = (rsp_nxt.res == '0);
  end

  // Result/zero only update on accepted ops; the strobe follows in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_q <= '{res: '0, zero: 1'b1};
      vld_q <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) rsp_q <= rsp_nxt;
    end
  end

  assign result    = rsp_q.res;
  assign zero      = rsp_q.zero;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_alu_unit.sv
// Directed-vector bench for alu_unit; expected values are hand-computed.
module tb_alu_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  ALU_Sel;
  logic [31:0] operand_0, operand_1;
  logic [31:0] result;
  logic        zero, out_valid;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, AND_ = 4'b0010,
    OR_ = 4'b0011, XOR_ = 4'b0100, SHL = 4'b0110, SHR = 4'b0111,
    SRA = 4'b1000, SLT = 4'b1001;

  alu_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .ALU_Sel(ALU_Sel),
    .operand_0(operand_0), .operand_1(operand_1),
    .result(result), .zero(zero), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] er,
                       input logic ez, input logic ev);
    vectors++;
    assert (result === er && zero === ez && out_valid === ev)
    else begin
      miscompares++;
      $error("FAIL %s: result=%h zero=%b out_valid=%b, expected result=%h zero=%b out_valid=%b",
             tag, result, zero, out_valid, er, ez, ev);
    end
  endtask

  // Present one op, clock it in, sample 1 time unit after the edge.
  task automatic op(input string tag, input logic [3:0] sel,
                    input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] er, input logic ez);
    in_valid = 1'b1; ALU_Sel = sel; operand_0 = a; operand_1 = b;
    @(posedge clk); #1;
    check(tag, er, ez, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; ALU_Sel = ADD;
    operand_0 = 32'd5; operand_1 = 32'd7;
    @(posedge clk); #1; check("reset_c1", 32'h0, 1'b1, 1'b0);
    @(posedge clk); #1; check("reset_c2", 32'h0, 1'b1, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1; check("post_reset_add", 32'd12, 1'b0, 1'b1);

    op("add_wrap",  ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1);
    op("sub_wrap",  SUB, 32'h0, 32'h1, 32'hFFFFFFFF, 1'b0);
    op("sub_10_3",  SUB, 32'd10, 32'd3, 32'd7, 1'b0);
    op("and",  AND_, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0);
    op("or",   OR_,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0);
    op("xor",  XOR_, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0);

    op("shl_1",   SHL, 32'h80000001, 32'h1,  32'h00000002, 1'b0);
    op("shr_1",   SHR, 32'h80000001, 32'h1,  32'h40000000, 1'b0);
    op("sra_1",   SRA, 32'h80000001, 32'h1,  32'hC0000000, 1'b0);
    op("shl_33",  SHL, 32'h80000001, 32'h21, 32'h00000002, 1'b0);
    op("shr_33",  SHR, 32'h80000001, 32'h21, 32'h40000000, 1'b0);
    op("sra_33",  SRA, 32'h80000001, 32'h21, 32'hC0000000, 1'b0);
    op("sra_31",  SRA, 32'h80000001, 32'd31, 32'hFFFFFFFF, 1'b0);
    op("shl_31",  SHL, 32'h80000001, 32'd31, 32'h80000000, 1'b0);
    op("shr_31",  SHR, 32'h80000001, 32'd31, 32'h00000001, 1'b0);
    op("sra_pos", SRA, 32'h40000000, 32'd4,  32'h04000000, 1'b0);
    op("sra_amt0", SRA, 32'h80000001, 32'hFFFFFFE0, 32'h80000001, 1'b0);
    op("shl_amt0", SHL, 32'h12345678, 32'h0, 32'h12345678, 1'b0);

    op("slt_neg1_1",  SLT, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0);
    op("slt_1_neg1",  SLT, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b1);
    op("slt_min_max", SLT, 32'h80000000, 32'h7FFFFFFF, 32'h1, 1'b0);
    op("slt_eq",      SLT, 32'd5, 32'd5, 32'h0, 1'b1);

    op("add_seed", ADD, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0);
    in_valid = 1'b0; ALU_Sel = SUB; operand_0 = 32'h0; operand_1 = 32'h0;
    @(posedge clk); #1; check("gap_hold1", 32'h12345678, 1'b0, 1'b0);
    @(posedge clk); #1; check("gap_hold2", 32'h12345678, 1'b0, 1'b0);

    op("unused_0101", 4'b0101, 32'hDEADBEEF, 32'h1, 32'h0, 1'b1);
    op("add_seed2",   ADD, 32'h1, 32'h1, 32'h2, 1'b0);
    op("unused_1111", 4'b1111, 32'hDEADBEEF, 32'h1, 32'h0, 1'b1);
    op("add_seed3",   ADD, 32'h3, 32'h4, 32'h7, 1'b0);
    op("unused_1010", 4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b1);

    op("add_pre_rst", ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0);
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1; check("reset_clears", 32'h0, 1'b1, 1'b0);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1; check("idle_after_rst", 32'h0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- 32-bit integer ALU with a registered output, used in the processor datapath execute stage.
- Takes two 32-bit operands and a 4-bit operation select.
- Produces a 32-bit result, a zero flag and a valid strobe one clock cycle later.
- Purely single-cycle: no multi-cycle operations, no back-pressure.

Parameters:
- WIDTH, 32, operand/result width in bits; only 32 is supported (shift amount field fixed at 5 bits).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands and ALU_Sel are valid this cycle
- ALU_Sel  input  4  operation select
- operand_0  input  32  first operand (A)
- operand_1  input  32  second operand (B; shift amount source for shifts)
- result  output  32  registered operation result
- zero  output  1  registered; 1 when result == 0
- out_valid  output  1  registered copy of in_valid

Behaviour:
- Reset (rst=1 at a rising clk edge):
  - result=0, zero=1, out_valid=0.
  - Reset overrides in_valid in the same cycle; an operation presented during reset is discarded.
- Latency and handshake:
  - Exactly 1 cycle from inputs to outputs.
  - If in_valid=1 at edge N (no reset), then at edge N: result <= f(ALU_Sel, A, B), zero <= (f==0), out_valid <= 1.
  - If in_valid=0 (no reset), result and zero hold their previous values and out_valid <= 0.
  - Back-to-back operations are accepted every cycle.
- Operation encoding (all arithmetic modulo 2^32):
  - 0000 ADD: A+B, carry discarded.
  - 0001 SUB: A-B, two's complement, borrow discarded.
  - 0010 AND: A&B.
  - 0011 OR: A|B.
  - 0100 XOR: A^B.
  - 0110 SHL_LOGICAL: A << B[4:0], zero fill.
  - 0111 SHR_LOGICAL: A >> B[4:0], zero fill.
  - 1000 SHR_ARITHMETIC: A >>> B[4:0], sign fill from A[31].
  - 1001 LESS_THAN: signed compare; result = 32'h1 if $signed(A) < $signed(B), else 32'h0.
  - Any other code (0101, 1010-1111): result = 32'h0, zero=1, out_valid still asserted.
- Shift rules:
  - B[31:5] is ignored.
  - Shift amount 0 returns A unchanged.
  - Shift amount 31 is the maximum.
- Boundary conditions:
  - ADD 0xFFFFFFFF+1 = 0 (zero=1).
  - SUB 0-1 = 0xFFFFFFFF.
  - LESS_THAN 0x80000000 < 0x7FFFFFFF is true (signed); LESS_THAN A<A is false.
- Outputs depend only on registered state; no combinational path from inputs to outputs.
- No X propagation from unused codes: every code yields a defined result.

Test Plan:
- Reset:
  - Assert rst for 2 cycles with in_valid=1, ADD, A=5, B=7 -> result=0, zero=1, out_valid=0.
  - Deassert rst -> next edge result=12, zero=0, out_valid=1.
- ADD/SUB wrap:
  - ADD 0xFFFFFFFF+0x00000001 -> result=0, zero=1.
  - SUB 0x00000000-0x00000001 -> 0xFFFFFFFF.
  - SUB 10-3 -> 7.
- Bitwise, A=0xF0F0F0F0, B=0xFF00FF00:
  - AND -> 0xF000F000.
  - OR -> 0xFFF0FFF0.
  - XOR -> 0x0FF00FF0.
- Shifts, A=0x80000001:
  - B=1: SHL -> 0x00000002; SHR -> 0x40000000; SRA -> 0xC0000000.
  - B=0x00000021 (amount 1): same three results.
  - SRA with B=31 -> 0xFFFFFFFF.
- LESS_THAN:
  - 0xFFFFFFFF vs 0x00000001 -> 1.
  - 0x00000001 vs 0xFFFFFFFF -> 0.
  - 0x80000000 vs 0x7FFFFFFF -> 1.
  - 5 vs 5 -> 0 with zero=1.
- Handshake and unused codes:
  - 1000 random back-to-back vectors per operation -> each result matches the golden model one cycle later.
  - in_valid=0 gap -> out_valid=0 and result held.
  - ALU_Sel=0101 or 1111 -> result=0, zero=1.
